// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Used by the converter top and its per-digit adjust cell.
package bcd_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Digit pattern shown on every position when the input is out of range
  localparam logic [3:0] BCD_ERR_DIGIT  = 4'hE;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal position.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= BCD_ADJ_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter feeding the seven-segment scanner.
// bcd_out only changes when a conversion completes, so the display never shows partial results.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int MAX_VAL = 9999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(BIN_W - 1);
  localparam logic [31:0]      MAX_VAL_U = 32'(MAX_VAL);

  state_t             state;
  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   work_q;
  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_next;
  logic [CNT_W-1:0]   cnt_q;
  logic               over_range;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (work_q[4*g +: 4]),
      .adjusted (work_adj[4*g +: 4])
    );
  end

  // The binary MSB enters the adjusted BCD word as its new LSB
  assign work_next  = {work_adj[BCD_W-2:0], shift_q[BIN_W-1]};
  // Full-width compare so that high bits are range-checked, never truncated
  assign over_range = 32'(bin_in) > MAX_VAL_U;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (over_range) begin
              bcd_out <= {DIGITS{BCD_ERR_DIGIT}};
              err     <= 1'b1;
              done    <= 1'b1;
            end else begin
              shift_q <= bin_in;
              work_q  <= '0;
              cnt_q   <= CNT_INIT;
              err     <= 1'b0;
              busy    <= 1'b1;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q  <= work_next;
          shift_q <= {shift_q[BIN_W-2:0], 1'b0};
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            bcd_out <= work_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a scoreboard queue holds the expected result of each
// accepted start, and every done pulse pops and compares one entry.
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;

  typedef struct packed {
    logic [15:0] bcd;
    logic        err;
  } result_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [15:0]      bcd_out;

  int      n_checks;
  int      n_fail;
  result_t sb_q[$];

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(4), .MAX_VAL(9999)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal digits by division, independent of the shift algorithm
  function automatic result_t model(input int value);
    result_t r;
    int v;
    if (value > 9999) begin
      r.bcd = 16'hEEEE;
      r.err = 1'b1;
    end else begin
      v = value;
      for (int d = 0; d < 4; d++) begin
        r.bcd[4*d +: 4] = 4'(v % 10);
        v = v / 10;
      end
      r.err = 1'b0;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents a one-cycle start; returns just after the accepting edge
  task automatic applyStimulus(input int value);
    start  = 1'b1;
    bin_in = BIN_W'(value);
    sb_q.push_back(model(value));
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for done, then pops the scoreboard and checks result, latency and busy time
  task automatic waitDone(input string tag, input int exp_lat);
    int cyc = 0;
    int busy_cnt = 0;
    bit seen = 0;
    result_t exp_r;
    while (!seen && cyc < 40) begin
      if (done === 1'b1) seen = 1;
      else begin
        if (busy === 1'b1) busy_cnt++;
        step();
        cyc++;
      end
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (sb_q.size() > 0) exp_r = sb_q.pop_front();
    else exp_r = '0;
    if (seen) begin
      checkOutput({tag, "_bcd"}, 32'(bcd_out), 32'(exp_r.bcd));
      checkOutput({tag, "_err"}, 32'(err), 32'(exp_r.err));
      checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
      checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  // Full conversion plus single-pulse and hold checks one cycle after done
  task automatic runConversion(input string tag, input int value, input int exp_lat);
    result_t exp_r;
    exp_r = model(value);
    applyStimulus(value);
    waitDone(tag, exp_lat);
    step();
    checkOutput({tag, "_done_single"}, 32'(done), 32'd0);
    checkOutput({tag, "_bcd_hold"}, 32'(bcd_out), 32'(exp_r.bcd));
  endtask

  initial begin
    int done_cnt;
    n_checks = 0;
    n_fail   = 0;
    rst_n  = 1'b0;
    start  = 1'b1;
    bin_in = BIN_W'(1234);

    // Reset held with start asserted
    repeat (3) step();
    checkOutput("rst_bcd", 32'(bcd_out), 32'h0000);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    start = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] main conversion and boundaries");
    applyStimulus(1234);
    checkOutput("c1234_busy_after_accept", 32'(busy), 32'd1);
    waitDone("c1234", BIN_W);
    step();
    checkOutput("c1234_done_single", 32'(done), 32'd0);
    runConversion("c0", 0, BIN_W);
    runConversion("c9999", 9999, BIN_W);
    runConversion("c5", 5, BIN_W);
    runConversion("c1000", 1000, BIN_W);

    $display("[TB] out of range then recovery");
    runConversion("c10000", 10000, 0);
    checkOutput("c10000_err_hold", 32'(err), 32'd1);
    checkOutput("c10000_busy_low", 32'(busy), 32'd0);
    applyStimulus(42);
    checkOutput("c42_err_cleared", 32'(err), 32'd0);
    checkOutput("c42_bcd_held", 32'(bcd_out), 32'hEEEE);
    waitDone("c42", BIN_W);
    step();

    $display("[TB] start during SHIFT ignored, start in done cycle accepted");
    applyStimulus(777);
    step();
    step();
    start  = 1'b1;
    bin_in = BIN_W'(555);
    step();
    start  = 1'b0;
    bin_in = BIN_W'(1);
    waitDone("c777", BIN_W - 3);
    applyStimulus(555);
    checkOutput("c555_busy_b2b", 32'(busy), 32'd1);
    checkOutput("c555_done_b2b", 32'(done), 32'd0);
    waitDone("c555", BIN_W);
    step();

    $display("[TB] reset mid-conversion");
    applyStimulus(4321);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    checkOutput("abort_bcd", 32'(bcd_out), 32'h0000);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    void'(sb_q.pop_back());
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) done_cnt++;
    end
    checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
    runConversion("c8", 8, BIN_W);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
